// File: rtl/uart_cfg_pkg.sv
// ----------------------------------------------------------------------------
// uart_cfg_pkg : shared constants, FSM encoding and baud divider for UART cfg link
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_cfg_pkg;

  localparam int         CFG_WORD_W = 20;
  localparam int         CFG_BYTES  = 3;
  localparam logic [7:0] PAD_MASK   = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ----------------------------------------------------------------------------
// uart_rx_byte : synchronised UART byte receiver, 8N1 (8E1 when UART_RX_PARITY_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx_byte
  import uart_cfg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_byte_err,
  output logic       o_busy
);

  localparam int                 c_CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]         r_sync;
  logic               r_rx_d;
  rx_state_t          r_state;
  rx_state_t          w_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_bits;
  logic [7:0]         r_shift;
  logic               r_hold;
  logic               w_rx;
  logic               w_fall;
  logic               w_tick;
  logic               w_par_err;
  logic               w_byte_valid;
  logic               w_byte_err;

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_d & ~w_rx;
  assign w_tick = (r_state == ST_START) ? (r_cnt == c_HALF_LAST) : (r_cnt == c_BIT_LAST);

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  assign w_par_err = r_par_err;
`else
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_byte_valid = 1'b0;
    w_byte_err   = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_fall) w_next = ST_START;
      ST_START: if (w_tick) w_next = w_rx ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (w_tick && (r_bits == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_next = ST_PARITY;
`else
          w_next = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (w_tick) w_next = ST_STOP;
`endif
      ST_STOP: begin
        // A low stop bit parks here until the line recovers so the break is not seen as a start
        if (r_hold) begin
          if (w_rx) w_next = ST_IDLE;
        end else if (w_tick) begin
          if (!w_rx || w_par_err) w_byte_err   = 1'b1;
          else                    w_byte_valid = 1'b1;
          if (w_rx) w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_rx_d  <= 1'b1;
      r_cnt   <= '0;
      r_bits  <= 3'd0;
      r_shift <= 8'h00;
      r_hold  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_rx_d <= w_rx;
      if ((r_state != w_next) || w_tick) r_cnt <= '0;
      else if (r_state != ST_IDLE)       r_cnt <= r_cnt + 1'b1;
      if (r_state == ST_START) r_bits <= 3'd0;
      if ((r_state == ST_DATA) && w_tick) begin
        r_shift <= {w_rx, r_shift[7:1]};
        if (r_bits != 3'd7) r_bits <= r_bits + 1'b1;
      end
      if ((r_state == ST_STOP) && !r_hold && w_tick && !w_rx) r_hold <= 1'b1;
      else if (w_next == ST_IDLE)                             r_hold <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     r_par_err <= 1'b0;
    else if (r_state == ST_START)                r_par_err <= 1'b0;
    else if ((r_state == ST_PARITY) && w_tick)   r_par_err <= w_rx ^ (^r_shift);
  end
`endif

  assign o_byte       = r_shift;
  assign o_byte_valid = w_byte_valid;
  assign o_byte_err   = w_byte_err;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: rtl/uart_rx_cfg.sv
// ----------------------------------------------------------------------------
// uart_rx_cfg : assembles 3-byte UART frames into 20-bit config words (UART_RX_PARITY_EN selects 8E1)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx_cfg
  import uart_cfg_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic [CFG_WORD_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int                 c_CPB      = clks_per_bit(CLK_FREQ, BAUD);
  localparam int                 c_TMO      = TIMEOUT_BITS * c_CPB;
  localparam int                 c_TMO_W    = $clog2(c_TMO + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(c_TMO - 1);
  localparam logic [1:0]         c_IDX_LAST = 2'(CFG_BYTES - 1);

  logic [7:0]         w_byte;
  logic               w_byte_valid;
  logic               w_byte_err;
  logic               w_byte_busy;
  logic               w_tmo_expire;
  logic [1:0]         r_idx;
  logic [7:0]         r_b0;
  logic [7:0]         r_b1;
  logic [c_TMO_W-1:0] r_tmo;

  uart_rx_byte #(
    .CLKS_PER_BIT(c_CPB)
  ) u_byte (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (uart_rx),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_byte_err  (w_byte_err),
    .o_busy      (w_byte_busy)
  );

  // Expiry outranks a coincident start edge: the byte then in flight becomes byte0
  assign w_tmo_expire = (r_idx != 2'd0) && !w_byte_busy && (r_tmo == c_TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      r_idx     <= 2'd0;
      r_b0      <= 8'h00;
      r_b1      <= 8'h00;
      r_tmo     <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if ((r_idx == 2'd0) || w_byte_busy || w_tmo_expire) r_tmo <= '0;
      else                                                r_tmo <= r_tmo + 1'b1;
      if (w_tmo_expire || w_byte_err) begin
        frame_err <= 1'b1;
        r_idx     <= 2'd0;
      end else if (w_byte_valid) begin
        if (r_idx == c_IDX_LAST) begin
          r_idx <= 2'd0;
          if ((w_byte & PAD_MASK) != 8'h00) begin
            frame_err <= 1'b1;
          end else begin
            rx_data  <= {w_byte[3:0], r_b1, r_b0};
            rx_valid <= 1'b1;
          end
        end else if (r_idx == 2'd0) begin
          r_b0  <= w_byte;
          r_idx <= 2'd1;
        end else begin
          r_b1  <= w_byte;
          r_idx <= 2'd2;
        end
      end
    end
  end

  assign busy = w_byte_busy | (r_idx != 2'd0);

endmodule

`default_nettype wire
